// File: rtl/int_ctrl.sv
// Purpose : edge-latched, fixed-priority interrupt controller plus main/interrupt zero-carry flag banks.
// Latency : irq edge at n -> pending at n+1 -> ENTER (take_int) at n+2 -> first ISR instruction at n+3.
// Backpr. : none; requests stay in pending until ie=1 and the FSM is IDLE, with no nesting.
// Ports   : clk/reset (async, active-high); irq, ie_set/ie_clr, reti, pc_next, flag_we, alu_zero/alu_carry in;
//           interruption, take_int/vector, take_ret/ret_pc, zero/carry, ie, pending, int_ack out.
module int_ctrl #(
    parameter int                     NUM_IRQ    = 4,
    parameter int                     PC_WIDTH   = 10,
    parameter logic [PC_WIDTH-1:0]    VEC_BASE   = 10'h3F0,
    parameter int                     VEC_STRIDE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                ie_set,
    input  logic                ie_clr,
    input  logic                reti,
    input  logic [PC_WIDTH-1:0] pc_next,
    input  logic                flag_we,
    input  logic                alu_zero,
    input  logic                alu_carry,
    output logic                interruption,
    output logic                take_int,
    output logic [PC_WIDTH-1:0] vector,
    output logic                take_ret,
    output logic [PC_WIDTH-1:0] ret_pc,
    output logic                zero,
    output logic                carry,
    output logic                ie,
    output logic [NUM_IRQ-1:0]  pending,
    output logic [NUM_IRQ-1:0]  int_ack
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {IDLE, ENTER, SERVICE, EXIT} state_t;

    state_t              state_q, state_d;
    logic [NUM_IRQ-1:0]  irq_q;
    logic [NUM_IRQ-1:0]  pending_q, pending_d;
    logic [NUM_IRQ-1:0]  int_ack_q, int_ack_d;
    logic [PC_WIDTH-1:0] vector_q, vector_d;
    logic [PC_WIDTH-1:0] ret_pc_q, ret_pc_d;
    logic                ie_q, ie_d;
    logic                zero_m_q, zero_m_d, carry_m_q, carry_m_d;
    logic                zero_i_q, zero_i_d, carry_i_q, carry_i_d;

    logic                sel_vld;
    logic [IDX_W-1:0]    sel_idx;
    logic                in_service;

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign in_service = (state_q == SERVICE);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        int_ack_d = int_ack_q;
        vector_d  = vector_q;
        ret_pc_d  = ret_pc_q;
        zero_m_d  = zero_m_q;
        carry_m_d = carry_m_q;
        zero_i_d  = zero_i_q;
        carry_i_d = carry_i_q;

        // Clear wins when both enable instructions collide.
        ie_d = ie_clr ? 1'b0 : (ie_set ? 1'b1 : ie_q);

        // Flags land in whichever bank the ALU is currently running in.
        if (flag_we) begin
            if (in_service) begin
                zero_i_d  = alu_zero;
                carry_i_d = alu_carry;
            end else begin
                zero_m_d  = alu_zero;
                carry_m_d = alu_carry;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (ie_q && sel_vld) begin
                    pending_d[sel_idx] = 1'b0;
                    int_ack_d          = NUM_IRQ'(1) << sel_idx;
                    vector_d           = VEC_BASE + PC_WIDTH'(sel_idx) * PC_WIDTH'(VEC_STRIDE);
                    state_d            = ENTER;
                end
            end
            ENTER: begin
                ret_pc_d  = pc_next;
                zero_i_d  = 1'b0;
                carry_i_d = 1'b0;
                state_d   = SERVICE;
            end
            SERVICE: begin
                if (reti) begin
                    int_ack_d = '0;
                    state_d   = EXIT;
                end
            end
            EXIT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge on the bit being selected is not lost: set beats clear.
        pending_d = pending_d | (irq & ~irq_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            int_ack_q <= '0;
            vector_q  <= '0;
            ret_pc_q  <= '0;
            ie_q      <= 1'b0;
            zero_m_q  <= 1'b0;
            carry_m_q <= 1'b0;
            zero_i_q  <= 1'b0;
            carry_i_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq;
            pending_q <= pending_d;
            int_ack_q <= int_ack_d;
            vector_q  <= vector_d;
            ret_pc_q  <= ret_pc_d;
            ie_q      <= ie_d;
            zero_m_q  <= zero_m_d;
            carry_m_q <= carry_m_d;
            zero_i_q  <= zero_i_d;
            carry_i_q <= carry_i_d;
        end
    end

    assign interruption = in_service;
    assign take_int     = (state_q == ENTER);
    assign take_ret     = (state_q == EXIT);
    assign vector       = vector_q;
    assign ret_pc       = ret_pc_q;
    assign ie           = ie_q;
    assign pending      = pending_q;
    assign int_ack      = int_ack_q;
    assign zero         = in_service ? zero_i_q  : zero_m_q;
    assign carry        = in_service ? carry_i_q : carry_m_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Purpose : directed bench for int_ctrl; expected vector/ack pairs are queued when a request is driven
//           and popped when the controller enters a service (take_int).
// Clocking: 10 ns clk; inputs change 1 ns after the rising edge, outputs are checked at that point too.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       ie_set, ie_clr, reti, flag_we, alu_zero, alu_carry;
    logic [9:0] pc_next;
    logic       interruption, take_int, take_ret, zero, carry, ie;
    logic [9:0] vector, ret_pc;
    logic [3:0] pending, int_ack;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [9:0] vec;
        logic [3:0] ack;
    } exp_t;

    exp_t sb_q[$];

    int_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .ie_set      (ie_set),
        .ie_clr      (ie_clr),
        .reti        (reti),
        .pc_next     (pc_next),
        .flag_we     (flag_we),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .interruption(interruption),
        .take_int    (take_int),
        .vector      (vector),
        .take_ret    (take_ret),
        .ret_pc      (ret_pc),
        .zero        (zero),
        .carry       (carry),
        .ie          (ie),
        .pending     (pending),
        .int_ack     (int_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [9:0] vec, input logic [3:0] ack);
        exp_t e;
        e.vec = vec;
        e.ack = ack;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 16'(sb_q.size() != 0), 16'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_vector"}, 16'(vector), 16'(e.vec));
            chk({tag, "_int_ack"}, 16'(int_ack), 16'(e.ack));
        end
    endtask

    task automatic wait_enter(input string tag);
        int n = 0;
        while (take_int !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_enter_seen"}, 16'(take_int), 16'd1);
        if (take_int === 1'b1) pop_cmp(tag);
    endtask

    initial begin
        reset = 1'b1; irq = '0; ie_set = 0; ie_clr = 0; reti = 0;
        flag_we = 0; alu_zero = 0; alu_carry = 0; pc_next = '0;
        #12 reset = 1'b0;
        #1;
        chk("rst_interruption", 16'(interruption), 16'd0);
        chk("rst_take_int", 16'(take_int), 16'd0);
        chk("rst_take_ret", 16'(take_ret), 16'd0);
        chk("rst_vector", 16'(vector), 16'd0);
        chk("rst_ret_pc", 16'(ret_pc), 16'd0);
        chk("rst_flags", 16'({zero, carry}), 16'd0);
        chk("rst_ie", 16'(ie), 16'd0);
        chk("rst_pending", 16'(pending), 16'd0);
        chk("rst_int_ack", 16'(int_ack), 16'd0);

        // 1: single request on irq[2], latency and return-PC capture
        tick(); ie_set = 1;
        tick(); ie_set = 0;
        chk("t1_ie", 16'(ie), 16'd1);
        irq = 4'b0100; push_exp(10'h3F8, 4'b0100);
        tick(); irq = '0; pc_next = 10'h123;
        chk("t1_pending_n1", 16'(pending), 16'b0100);
        chk("t1_no_enter_n1", 16'(take_int), 16'd0);
        tick();
        chk("t1_enter_n2", 16'(take_int), 16'd1);
        chk("t1_interruption_enter", 16'(interruption), 16'd0);
        chk("t1_pending_cleared", 16'(pending), 16'd0);
        pop_cmp("t1");
        tick(); pc_next = 10'h000;
        chk("t1_service", 16'(interruption), 16'd1);
        chk("t1_ret_pc", 16'(ret_pc), 16'h123);
        chk("t1_ack_service", 16'(int_ack), 16'b0100);
        chk("t1_take_int_off", 16'(take_int), 16'd0);
        reti = 1;
        tick(); reti = 0;
        chk("t1_exit", 16'(take_ret), 16'd1);
        chk("t1_exit_intr", 16'(interruption), 16'd0);
        chk("t1_exit_ack", 16'(int_ack), 16'd0);
        tick();
        chk("t1_idle", 16'({take_ret, take_int, interruption}), 16'd0);

        // 2: simultaneous irq[3] and irq[1], priority then back-to-back
        irq = 4'b1010; push_exp(10'h3F4, 4'b0010); push_exp(10'h3FC, 4'b1000);
        tick(); irq = '0;
        wait_enter("t2a");
        tick();
        chk("t2a_ack", 16'(int_ack), 16'b0010);
        chk("t2a_pending", 16'(pending), 16'b1000);
        reti = 1;
        tick(); reti = 0;
        chk("t2_exit", 16'({take_ret, take_int}), 16'b10);
        tick();
        chk("t2_idle_between", 16'({take_ret, take_int, interruption}), 16'd0);
        tick();
        chk("t2b_enter_after_one_idle", 16'(take_int), 16'd1);
        pop_cmp("t2b");
        tick();
        chk("t2b_ack", 16'(int_ack), 16'b1000);
        reti = 1;
        tick(); reti = 0;
        tick();

        // 3: flag banks swap around a service
        flag_we = 1; alu_zero = 1; alu_carry = 0;
        tick(); flag_we = 0;
        chk("t3_main_flags", 16'({zero, carry}), 16'b10);
        irq = 4'b0001; push_exp(10'h3F0, 4'b0001);
        tick(); irq = '0;
        wait_enter("t3");
        chk("t3_enter_main_flags", 16'({zero, carry}), 16'b10);
        tick();
        chk("t3_int_bank_cleared", 16'({zero, carry}), 16'b00);
        flag_we = 1; alu_zero = 0; alu_carry = 1;
        tick(); flag_we = 0;
        chk("t3_int_flags", 16'({zero, carry}), 16'b01);
        reti = 1;
        tick(); reti = 0;
        chk("t3_exit_restored", 16'({zero, carry}), 16'b10);
        tick();
        chk("t3_idle_restored", 16'({zero, carry}), 16'b10);

        // 4: request held while disabled, released by ie_set; set+clr -> clear
        ie_set = 1; ie_clr = 1;
        tick(); ie_set = 0; ie_clr = 0;
        chk("t4_setclr_ie", 16'(ie), 16'd0);
        irq = 4'b0001;
        tick(); irq = '0;
        tick(); tick();
        chk("t4_pending_held", 16'(pending), 16'b0001);
        chk("t4_stays_idle", 16'({take_int, interruption}), 16'd0);
        ie_set = 1; push_exp(10'h3F0, 4'b0001);
        tick(); ie_set = 0;
        chk("t4_ie_on", 16'(ie), 16'd1);
        chk("t4_not_yet", 16'(take_int), 16'd0);
        pc_next = 10'h2AA;
        tick();
        chk("t4_enter_2cyc", 16'(take_int), 16'd1);
        pop_cmp("t4");
        tick(); pc_next = '0;

        // 5: async reset in the middle of SERVICE
        flag_we = 1; alu_zero = 1; alu_carry = 1; irq = 4'b0100;
        tick(); flag_we = 0; irq = '0;
        chk("t5_pre_flags", 16'({zero, carry}), 16'b11);
        chk("t5_pre_pending", 16'(pending), 16'b0100);
        chk("t5_pre_ret_pc", 16'(ret_pc), 16'h2AA);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_intr", 16'(interruption), 16'd0);
        chk("t5_rst_ack", 16'(int_ack), 16'd0);
        chk("t5_rst_pending", 16'(pending), 16'd0);
        chk("t5_rst_ret_pc", 16'(ret_pc), 16'd0);
        chk("t5_rst_flags", 16'({zero, carry}), 16'd0);
        chk("t5_rst_ie", 16'(ie), 16'd0);
        #1 reset = 1'b0;
        tick();
        chk("t5_idle_after", 16'({take_ret, take_int, interruption}), 16'd0);
        chk("t5_main_bank_zero", 16'({zero, carry}), 16'd0);

        // 6: reti outside SERVICE has no effect
        ie_set = 1;
        tick(); ie_set = 0; reti = 1;
        tick(); reti = 0;
        chk("t6_reti_idle", 16'({take_ret, take_int, interruption}), 16'd0);
        irq = 4'b1000; push_exp(10'h3FC, 4'b1000);
        tick(); irq = '0;
        tick();
        chk("t6_enter", 16'(take_int), 16'd1);
        pop_cmp("t6");
        reti = 1;
        tick(); reti = 0;
        chk("t6_reti_enter_ignored", 16'({take_ret, interruption}), 16'b01);
        reti = 1;
        tick(); reti = 0;
        chk("t6_exit", 16'(take_ret), 16'd1);
        tick();
        chk("t6_sb_drained", 16'(sb_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
